// File: rtl/img_pattern_gen_pkg.sv
// Shared stream definitions for the imager pipeline: beat type codes, pattern
// select encodings and the pattern generator state encoding.
package img_pattern_gen_pkg;

  localparam int DTYPE_WIDTH = 4;

  localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_START  = 4'd1;
  localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_END    = 4'd2;
  localparam logic [DTYPE_WIDTH-1:0] DT_ROW_START    = 4'd3;
  localparam logic [DTYPE_WIDTH-1:0] DT_ROW_END      = 4'd4;
  localparam logic [DTYPE_WIDTH-1:0] DT_PIXEL        = 4'd5;
  localparam logic [DTYPE_WIDTH-1:0] DT_HEADER_START = 4'd6;
  localparam logic [DTYPE_WIDTH-1:0] DT_HEADER       = 4'd7;
  localparam logic [DTYPE_WIDTH-1:0] DT_HEADER_END   = 4'd8;

  localparam logic [1:0] PAT_HRAMP  = 2'd0;
  localparam logic [1:0] PAT_VRAMP  = 2'd1;
  localparam logic [1:0] PAT_CHECK  = 2'd2;
  localparam logic [1:0] PAT_LINEAR = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FSTART = 4'd1,
    ST_HDR    = 4'd2,
    ST_RSTART = 4'd3,
    ST_PIX    = 4'd4,
    ST_REND   = 4'd5,
    ST_RGAP   = 4'd6,
    ST_FEND   = 4'd7,
    ST_FGAP   = 4'd8
  } state_t;

endpackage

// File: rtl/img_pattern_pixel.sv
// Pixel value for a given (pattern, row, col, num_cols); purely combinational.
// Values are formed at full width and truncated or zero-extended to DATA_WIDTH.
module img_pattern_pixel
  import img_pattern_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DIM_WIDTH  = 12
) (
  input  logic [1:0]            pattern,
  input  logic [DIM_WIDTH-1:0]  row,
  input  logic [DIM_WIDTH-1:0]  col,
  input  logic [DIM_WIDTH-1:0]  num_cols,
  output logic [DATA_WIDTH-1:0] pixel
);

  localparam int LIN_W  = 2 * DIM_WIDTH;
  localparam int FULL_W = (DATA_WIDTH > LIN_W) ? DATA_WIDTH : LIN_W;

  logic [LIN_W-1:0]  linear_s;
  logic [FULL_W-1:0] full_s;

  // Pattern select and width fitting
  always_comb begin
    linear_s = LIN_W'(row) * LIN_W'(num_cols) + LIN_W'(col);
    full_s   = '0;
    case (pattern)
      PAT_HRAMP:  full_s = FULL_W'(col);
      PAT_VRAMP:  full_s = FULL_W'(row);
      PAT_CHECK:  full_s = (col[3] ^ row[3]) ? '1 : '0;
      PAT_LINEAR: full_s = FULL_W'(linear_s);
      default:    full_s = '0;
    endcase
    pixel = full_s[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/img_pattern_gen.sv
// Synthetic framed test-pattern source for the dvi/dtypeo/datao image stream.
// Define IMG_PATTERN_GEN_HEADER_EN to insert a 5-beat geometry header after FRAME_START.
module img_pattern_gen
  import img_pattern_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DIM_WIDTH  = 12,
  parameter int GAP_WIDTH  = 8
) (
  input  logic                   img_clk,
  input  logic                   resetb,
  input  logic                   enable,
  input  logic [DIM_WIDTH-1:0]   num_cols,
  input  logic [DIM_WIDTH-1:0]   num_rows,
  input  logic [1:0]             pattern,
  input  logic [GAP_WIDTH-1:0]   row_gap,
  input  logic [GAP_WIDTH-1:0]   frame_gap,
  output logic                   dvi,
  output logic [DTYPE_WIDTH-1:0] dtypeo,
  output logic [DATA_WIDTH-1:0]  datao,
  output logic                   busy,
  output logic [15:0]            frame_count
);

  state_t                state_r;
  logic [DIM_WIDTH-1:0]  cols_r;
  logic [DIM_WIDTH-1:0]  rows_r;
  logic [DIM_WIDTH-1:0]  col_r;
  logic [DIM_WIDTH-1:0]  row_r;
  logic [1:0]            pattern_r;
  logic [GAP_WIDTH-1:0]  row_gap_r;
  logic [GAP_WIDTH-1:0]  frame_gap_r;
  logic [GAP_WIDTH-1:0]  gap_r;
  logic [DIM_WIDTH-1:0]  pix_col_s;
  logic [DATA_WIDTH-1:0] pix_s;
  logic                  frame_edge_s;
  logic                  can_start_s;
`ifdef IMG_PATTERN_GEN_HEADER_EN
  logic [2:0]            hdr_idx_r;
`endif

  // Column of the pixel beat that the next edge will emit
  always_comb begin
    if (state_r == ST_RSTART) begin
      pix_col_s = '0;
    end else begin
      pix_col_s = col_r + DIM_WIDTH'(1);
    end
  end

  // Frame boundary: the only points where enable and configuration are sampled
  always_comb begin
    can_start_s = enable && (num_cols != '0) && (num_rows != '0);
    if (state_r == ST_IDLE) begin
      frame_edge_s = 1'b1;
    end else if (state_r == ST_FEND) begin
      frame_edge_s = (frame_gap_r == '0);
    end else if (state_r == ST_FGAP) begin
      frame_edge_s = (gap_r == frame_gap_r - GAP_WIDTH'(1));
    end else begin
      frame_edge_s = 1'b0;
    end
  end

  img_pattern_pixel #(
    .DATA_WIDTH (DATA_WIDTH),
    .DIM_WIDTH  (DIM_WIDTH)
  ) u_pixel (
    .pattern  (pattern_r),
    .row      (row_r),
    .col      (pix_col_s),
    .num_cols (cols_r),
    .pixel    (pix_s)
  );

  // Frame sequencer; outputs always carry the beat of the current state
  always_ff @(posedge img_clk or negedge resetb) begin
    if (!resetb) begin
      state_r     <= ST_IDLE;
      cols_r      <= '0;
      rows_r      <= '0;
      col_r       <= '0;
      row_r       <= '0;
      pattern_r   <= 2'd0;
      row_gap_r   <= '0;
      frame_gap_r <= '0;
      gap_r       <= '0;
      dvi         <= 1'b0;
      dtypeo      <= '0;
      datao       <= '0;
      busy        <= 1'b0;
      frame_count <= 16'd0;
`ifdef IMG_PATTERN_GEN_HEADER_EN
      hdr_idx_r   <= 3'd0;
`endif
    end else if (frame_edge_s) begin
      if (can_start_s) begin
        cols_r      <= num_cols;
        rows_r      <= num_rows;
        pattern_r   <= pattern;
        row_gap_r   <= row_gap;
        frame_gap_r <= frame_gap;
        state_r     <= ST_FSTART;
        dvi         <= 1'b1;
        dtypeo      <= DT_FRAME_START;
        datao       <= DATA_WIDTH'(frame_count);
        busy        <= 1'b1;
      end else begin
        state_r <= ST_IDLE;
        dvi     <= 1'b0;
        busy    <= 1'b0;
      end
    end else begin
      case (state_r)
        ST_FSTART: begin
`ifdef IMG_PATTERN_GEN_HEADER_EN
          state_r   <= ST_HDR;
          hdr_idx_r <= 3'd0;
          dvi       <= 1'b1;
          dtypeo    <= DT_HEADER_START;
          datao     <= '0;
`else
          state_r <= ST_RSTART;
          row_r   <= '0;
          dvi     <= 1'b1;
          dtypeo  <= DT_ROW_START;
          datao   <= '0;
`endif
        end
`ifdef IMG_PATTERN_GEN_HEADER_EN
        ST_HDR: begin
          hdr_idx_r <= hdr_idx_r + 3'd1;
          case (hdr_idx_r)
            3'd0: begin
              dtypeo <= DT_HEADER;
              datao  <= DATA_WIDTH'(cols_r);
            end
            3'd1: begin
              dtypeo <= DT_HEADER;
              datao  <= DATA_WIDTH'(rows_r);
            end
            3'd2: begin
              dtypeo <= DT_HEADER;
              datao  <= DATA_WIDTH'(frame_count);
            end
            3'd3: begin
              dtypeo <= DT_HEADER_END;
              datao  <= '0;
            end
            default: begin
              state_r <= ST_RSTART;
              row_r   <= '0;
              dtypeo  <= DT_ROW_START;
              datao   <= '0;
            end
          endcase
        end
`endif
        ST_RSTART: begin
          state_r <= ST_PIX;
          col_r   <= '0;
          dtypeo  <= DT_PIXEL;
          datao   <= pix_s;
        end
        ST_PIX: begin
          if (col_r == cols_r - DIM_WIDTH'(1)) begin
            state_r <= ST_REND;
            dtypeo  <= DT_ROW_END;
            datao   <= DATA_WIDTH'(row_r);
          end else begin
            col_r <= col_r + DIM_WIDTH'(1);
            datao <= pix_s;
          end
        end
        ST_REND: begin
          if (row_r == rows_r - DIM_WIDTH'(1)) begin
            state_r     <= ST_FEND;
            dtypeo      <= DT_FRAME_END;
            datao       <= DATA_WIDTH'(frame_count);
            frame_count <= frame_count + 16'd1;
          end else if (row_gap_r == '0) begin
            state_r <= ST_RSTART;
            row_r   <= row_r + DIM_WIDTH'(1);
            dtypeo  <= DT_ROW_START;
            datao   <= DATA_WIDTH'(row_r + DIM_WIDTH'(1));
          end else begin
            state_r <= ST_RGAP;
            gap_r   <= '0;
            dvi     <= 1'b0;
          end
        end
        ST_RGAP: begin
          if (gap_r == row_gap_r - GAP_WIDTH'(1)) begin
            state_r <= ST_RSTART;
            row_r   <= row_r + DIM_WIDTH'(1);
            dvi     <= 1'b1;
            dtypeo  <= DT_ROW_START;
            datao   <= DATA_WIDTH'(row_r + DIM_WIDTH'(1));
          end else begin
            gap_r <= gap_r + GAP_WIDTH'(1);
          end
        end
        ST_FEND: begin
          state_r <= ST_FGAP;
          gap_r   <= '0;
          dvi     <= 1'b0;
        end
        ST_FGAP: begin
          gap_r <= gap_r + GAP_WIDTH'(1);
        end
        default: begin
          state_r <= ST_IDLE;
          dvi     <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_img_pattern_gen.sv
// Self-checking bench for img_pattern_gen: directed beat tables, configuration
// tables and randomized frames checked against a per-cycle stream model.
module tb_img_pattern_gen;
  import img_pattern_gen_pkg::*;

`ifdef IMG_PATTERN_GEN_HEADER_EN
  localparam int HDR_EXTRA = 5;
`else
  localparam int HDR_EXTRA = 0;
`endif

  typedef struct {
    logic        dvi;
    logic [3:0]  dt;
    logic [15:0] data;
  } vec_t;

  typedef struct {
    int cols;
    int rows;
    int pat;
    int rg;
    int fg;
    int exp_len;
  } cfg_t;

  logic        img_clk;
  logic        resetb;
  logic        enable;
  logic [11:0] num_cols;
  logic [11:0] num_rows;
  logic [1:0]  pattern;
  logic [7:0]  row_gap;
  logic [7:0]  frame_gap;
  logic        dvi;
  logic [3:0]  dtypeo;
  logic [15:0] datao;
  logic        busy;
  logic [15:0] frame_count;

  int          total = 0;
  int          bad = 0;
  vec_t        q[$];
  vec_t        tv[$];
  cfg_t        cfgs[6];
  int          fc_model = 0;
  logic [3:0]  last_dt = 4'd0;
  logic [15:0] last_data = 16'd0;

  img_pattern_gen dut (
    .img_clk     (img_clk),
    .resetb      (resetb),
    .enable      (enable),
    .num_cols    (num_cols),
    .num_rows    (num_rows),
    .pattern     (pattern),
    .row_gap     (row_gap),
    .frame_gap   (frame_gap),
    .dvi         (dvi),
    .dtypeo      (dtypeo),
    .datao       (datao),
    .busy        (busy),
    .frame_count (frame_count)
  );

  initial img_clk = 1'b0;
  always #5 img_clk = ~img_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_pix(int pat, int r, int c, int cols);
    case (pat)
      0: return 16'(c);
      1: return 16'(r);
      2: return (((c / 8) % 2) != ((r / 8) % 2)) ? 16'hFFFF : 16'h0000;
      default: return 16'((r * cols + c) % 65536);
    endcase
  endfunction

  function automatic void push_beat(logic [3:0] dt, int data);
    vec_t v;
    v.dvi = 1'b1;
    v.dt = dt;
    v.data = 16'(data);
    q.push_back(v);
    last_dt = dt;
    last_data = v.data;
  endfunction

  function automatic void push_idle();
    vec_t v;
    v.dvi = 1'b0;
    v.dt = last_dt;
    v.data = last_data;
    q.push_back(v);
  endfunction

  function automatic void build_frame(int cols, int rows, int pat, int rg, int fg);
    push_beat(DT_FRAME_START, fc_model);
`ifdef IMG_PATTERN_GEN_HEADER_EN
    push_beat(DT_HEADER_START, 0);
    push_beat(DT_HEADER, cols);
    push_beat(DT_HEADER, rows);
    push_beat(DT_HEADER, fc_model);
    push_beat(DT_HEADER_END, 0);
`endif
    for (int r = 0; r < rows; r++) begin
      push_beat(DT_ROW_START, r);
      for (int c = 0; c < cols; c++) push_beat(DT_PIXEL, int'(model_pix(pat, r, c, cols)));
      push_beat(DT_ROW_END, r);
      if (r < rows - 1) for (int g = 0; g < rg; g++) push_idle();
    end
    push_beat(DT_FRAME_END, fc_model);
    fc_model = (fc_model + 1) % 65536;
    for (int g = 0; g < fg; g++) push_idle();
  endfunction

  function automatic void add_tv(logic d, logic [3:0] dt, int data);
    vec_t v;
    v.dvi = d;
    v.dt = dt;
    v.data = 16'(data);
    tv.push_back(v);
  endfunction

  task automatic set_cfg(input int c, input int r, input int p, input int rg, input int fg);
    num_cols = 12'(c);
    num_rows = 12'(r);
    pattern = 2'(p);
    row_gap = 8'(rg);
    frame_gap = 8'(fg);
  endtask

  // Play the expected queue: caller leaves the DUT idle at a negedge with enable=1.
  task automatic run_q(input int drop_at, input int chg_at, input int chg_cols,
                       input bit scramble, output int busy_cnt);
    busy_cnt = 0;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge img_clk);
      chk($sformatf("dvi[%0d]", i), 32'(dvi), 32'(q[i].dvi));
      chk($sformatf("dtype[%0d]", i), 32'(dtypeo), 32'(q[i].dt));
      chk($sformatf("data[%0d]", i), 32'(datao), 32'(q[i].data));
      chk($sformatf("busy[%0d]", i), 32'(busy), 32'd1);
      if (busy) busy_cnt++;
      if (i == chg_at) num_cols = 12'(chg_cols);
      if (i == drop_at) begin
        enable = 1'b0;
        if (scramble) begin
          set_cfg($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
                  $urandom_range(0, 9), $urandom_range(0, 9));
        end
      end
    end
    @(negedge img_clk);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_dvi", 32'(dvi), 32'd0);
    chk("end_frame_count", 32'(frame_count), 32'(fc_model));
    @(negedge img_clk);
    chk("no_restart", 32'(dvi), 32'd0);
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(negedge img_clk);
      n++;
    end
    chk("idle_reached", 32'(busy === 1'b0), 32'd1);
  endtask

  initial begin
    int cnt;
    int nf;
    int flen;
    int drop;
    int rc, rr, rp, rrg, rfg;

    resetb = 1'b0;
    enable = 1'b0;
    set_cfg(0, 0, 0, 0, 0);

`ifdef IMG_PATTERN_GEN_HEADER_EN
    add_tv(1, DT_FRAME_START, 0);
    add_tv(1, DT_HEADER_START, 0);
    add_tv(1, DT_HEADER, 2);
    add_tv(1, DT_HEADER, 1);
    add_tv(1, DT_HEADER, 0);
    add_tv(1, DT_HEADER_END, 0);
    add_tv(1, DT_ROW_START, 0);
    add_tv(1, DT_PIXEL, 0);
    add_tv(1, DT_PIXEL, 1);
    add_tv(1, DT_ROW_END, 0);
    add_tv(1, DT_FRAME_END, 0);
    add_tv(1, DT_FRAME_START, 1);
`else
    add_tv(1, DT_FRAME_START, 0);
    add_tv(1, DT_ROW_START, 0);
    for (int c = 0; c < 4; c++) add_tv(1, DT_PIXEL, c);
    add_tv(1, DT_ROW_END, 0);
    add_tv(1, DT_ROW_START, 1);
    for (int c = 0; c < 4; c++) add_tv(1, DT_PIXEL, c);
    add_tv(1, DT_ROW_END, 1);
    add_tv(1, DT_FRAME_END, 0);
    add_tv(1, DT_FRAME_START, 1);
`endif

    cfgs[0] = '{4, 2, 0, 0, 0, 14 + HDR_EXTRA};
    cfgs[1] = '{3, 3, 3, 2, 5, 26 + HDR_EXTRA};
    cfgs[2] = '{1, 1, 2, 0, 0, 5 + HDR_EXTRA};
    cfgs[3] = '{16, 2, 2, 1, 3, 42 + HDR_EXTRA};
    cfgs[4] = '{5, 4, 1, 3, 0, 39 + HDR_EXTRA};
    cfgs[5] = '{2, 3, 3, 0, 1, 15 + HDR_EXTRA};

    repeat (3) @(negedge img_clk);
    chk("rst_dvi", 32'(dvi), 32'd0);
    chk("rst_dtype", 32'(dtypeo), 32'd0);
    chk("rst_data", 32'(datao), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    resetb = 1'b1;

    // Directed beat table, enable held so the second frame follows back to back
`ifdef IMG_PATTERN_GEN_HEADER_EN
    set_cfg(2, 1, 0, 0, 0);
`else
    set_cfg(4, 2, 0, 0, 0);
`endif
    enable = 1'b1;
    for (int i = 0; i < tv.size(); i++) begin
      @(negedge img_clk);
      chk($sformatf("tv_dvi[%0d]", i), 32'(dvi), 32'(tv[i].dvi));
      chk($sformatf("tv_dtype[%0d]", i), 32'(dtypeo), 32'(tv[i].dt));
      chk($sformatf("tv_data[%0d]", i), 32'(datao), 32'(tv[i].data));
    end
    enable = 1'b0;
    wait_idle(200);
    chk("tv_frame_count", 32'(frame_count), 32'd2);
    fc_model = 2;

    // Configuration table, each frame with inputs scrambled right after launch
    foreach (cfgs[k]) begin
      q.delete();
      build_frame(cfgs[k].cols, cfgs[k].rows, cfgs[k].pat, cfgs[k].rg, cfgs[k].fg);
      set_cfg(cfgs[k].cols, cfgs[k].rows, cfgs[k].pat, cfgs[k].rg, cfgs[k].fg);
      enable = 1'b1;
      run_q(0, -1, 0, 1'b1, cnt);
      chk($sformatf("frame_len[%0d]", k), 32'(cnt), 32'(cfgs[k].exp_len));
    end

    // Enable dropped during row 1: the frame still completes, no second frame
    q.delete();
    build_frame(4, 2, 1, 1, 2);
    set_cfg(4, 2, 1, 1, 2);
    enable = 1'b1;
    run_q(10 + HDR_EXTRA, -1, 0, 1'b0, cnt);

    // num_cols 4 -> 8 mid-frame applies only to the following frame
    q.delete();
    build_frame(4, 2, 0, 0, 0);
    flen = q.size();
    build_frame(8, 2, 0, 0, 0);
    set_cfg(4, 2, 0, 0, 0);
    enable = 1'b1;
    run_q(flen + 2, 3, 8, 1'b0, cnt);

    // Zero dimensions never start a frame
    set_cfg(4, 0, 0, 0, 0);
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge img_clk);
      chk("zero_rows_dvi", 32'(dvi), 32'd0);
      chk("zero_rows_busy", 32'(busy), 32'd0);
    end
    set_cfg(0, 2, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge img_clk);
      chk("zero_cols_dvi", 32'(dvi), 32'd0);
      chk("zero_cols_busy", 32'(busy), 32'd0);
    end
    enable = 1'b0;

    // Asynchronous reset in the middle of the pixels
    set_cfg(4, 2, 0, 0, 0);
    enable = 1'b1;
    repeat (4 + HDR_EXTRA) @(negedge img_clk);
    chk("pre_reset_dtype", 32'(dtypeo), 32'(DT_PIXEL));
    #2 resetb = 1'b0;
    #1;
    chk("arst_dvi", 32'(dvi), 32'd0);
    chk("arst_dtype", 32'(dtypeo), 32'd0);
    chk("arst_data", 32'(datao), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_frame_count", 32'(frame_count), 32'd0);
    @(negedge img_clk);
    resetb = 1'b1;
    fc_model = 0;
    last_dt = 4'd0;
    last_data = 16'd0;
    q.delete();
    build_frame(4, 2, 0, 0, 0);
    run_q(0, -1, 0, 1'b0, cnt);
    chk("post_reset_len", 32'(cnt), 32'(14 + HDR_EXTRA));

    // Randomized configurations, one or two back-to-back frames
    for (int it = 0; it < 12; it++) begin
      rc = $urandom_range(1, 20);
      rr = $urandom_range(1, 4);
      rp = $urandom_range(0, 3);
      rrg = $urandom_range(0, 3);
      rfg = $urandom_range(0, 4);
      nf = $urandom_range(1, 2);
      q.delete();
      for (int f = 0; f < nf; f++) build_frame(rc, rr, rp, rrg, rfg);
      flen = q.size() / nf;
      drop = $urandom_range(flen * (nf - 1), q.size() - 1);
      set_cfg(rc, rr, rp, rrg, rfg);
      enable = 1'b1;
      run_q(drop, -1, 0, 1'b1, cnt);
      chk($sformatf("rand_len[%0d]", it), 32'(cnt), 32'(q.size()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
